// File: rtl/dvp_pkg.sv
// Shared constants for the DVP RGB565 to gray-scale converter.
// The luma weights approximate BT.601 (0.299, 0.587, 0.114) scaled by 256.
package dvp_pkg;

  localparam logic [15:0] GS_COEF_R      = 16'd77;
  localparam logic [15:0] GS_COEF_G      = 16'd150;
  localparam logic [15:0] GS_COEF_B      = 16'd29;
  localparam int unsigned GS_SHIFT       = 8;
  localparam logic [15:0] GS_ROUND_CONST = 16'd128;

  // Worst case 255 * coefficient stays below 2^16, so a 16-bit product is exact.
  function automatic logic [15:0] gs_weight(input logic [7:0] chan, input logic [15:0] coef);
    return 16'(chan) * coef;
  endfunction

endpackage

// File: rtl/dvp_gray_scale_if.sv
// Pixel stream bundle: RGB565 pixels in, gray-scale pixels out.
// A beat moves on a channel only in a cycle where its valid and ready are both high.
interface dvp_gray_scale_if #(
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = 8
);

  logic [RGB_PXL_W-1:0] rgb_pxl;
  logic                 rgb_pxl_vld;
  logic                 rgb_pxl_rdy;
  logic [GS_PXL_W-1:0]  gs_pxl;
  logic                 gs_pxl_vld;
  logic                 gs_pxl_rdy;

  modport master (
    output rgb_pxl,
    output rgb_pxl_vld,
    input  rgb_pxl_rdy,
    input  gs_pxl,
    input  gs_pxl_vld,
    output gs_pxl_rdy
  );

  modport slave (
    input  rgb_pxl,
    input  rgb_pxl_vld,
    output rgb_pxl_rdy,
    output gs_pxl,
    output gs_pxl_vld,
    input  gs_pxl_rdy
  );

endinterface

// File: rtl/rgb565_expand.sv
// Widens RGB565 channels to 8 bits by replicating the channel MSBs into the LSBs,
// so full-scale inputs map exactly to 255.
module rgb565_expand (
  input  logic [15:0] rgb565_i,
  output logic [7:0]  r8_o,
  output logic [7:0]  g8_o,
  output logic [7:0]  b8_o
);

  assign r8_o = {rgb565_i[15:11], rgb565_i[15:13]};
  assign g8_o = {rgb565_i[10:5],  rgb565_i[10:9]};
  assign b8_o = {rgb565_i[4:0],   rgb565_i[4:2]};

endmodule

// File: rtl/dvp_gray_scale.sv
// Two-stage RGB565 to gray-scale pipeline: weighted products, then sum and shift.
// Define GS_ROUND_EN to round to nearest instead of truncating.
module dvp_gray_scale
  import dvp_pkg::*;
#(
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RGB_PXL_W-1:0] rgb_pxl_i,
  input  logic                 rgb_pxl_vld_i,
  output logic                 rgb_pxl_rdy_o,
  output logic [GS_PXL_W-1:0]  gs_pxl_o,
  output logic                 gs_pxl_vld_o,
  input  logic                 gs_pxl_rdy_i
);

  logic [7:0] r8, g8, b8;

  rgb565_expand u_expand (
    .rgb565_i (rgb_pxl_i),
    .r8_o     (r8),
    .g8_o     (g8),
    .b8_o     (b8)
  );

  logic                s1_vld_q, s1_vld_d;
  logic [15:0]         prod_r_q, prod_r_d;
  logic [15:0]         prod_g_q, prod_g_d;
  logic [15:0]         prod_b_q, prod_b_d;
  logic                s2_vld_q, s2_vld_d;
  logic [GS_PXL_W-1:0] gs_q, gs_d;
  logic [15:0]         sum;
  logic                s1_en, s2_en;

  // A stage loads when it is empty or its current contents leave this cycle.
  assign s2_en         = ~s2_vld_q | gs_pxl_rdy_i;
  assign s1_en         = ~s1_vld_q | s2_en;
  assign rgb_pxl_rdy_o = s1_en;
  assign gs_pxl_o      = gs_q;
  assign gs_pxl_vld_o  = s2_vld_q;

  always_comb begin
    s1_vld_d = s1_vld_q;
    prod_r_d = prod_r_q;
    prod_g_d = prod_g_q;
    prod_b_d = prod_b_q;
    if (s1_en) begin
      s1_vld_d = rgb_pxl_vld_i;
      if (rgb_pxl_vld_i) begin
        prod_r_d = gs_weight(r8, GS_COEF_R);
        prod_g_d = gs_weight(g8, GS_COEF_G);
        prod_b_d = gs_weight(b8, GS_COEF_B);
      end
    end
  end

  // The weights sum to 256, so even with the rounding term the total peaks at 65408.
  always_comb begin
`ifdef GS_ROUND_EN
    sum = prod_r_q + prod_g_q + prod_b_q + GS_ROUND_CONST;
`else
    sum = prod_r_q + prod_g_q + prod_b_q;
`endif
    s2_vld_d = s2_vld_q;
    gs_d     = gs_q;
    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        gs_d = GS_PXL_W'(sum >> GS_SHIFT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      s2_vld_q <= 1'b0;
      gs_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      prod_r_q <= prod_r_d;
      prod_g_q <= prod_g_d;
      prod_b_q <= prod_b_d;
      s2_vld_q <= s2_vld_d;
      gs_q     <= gs_d;
    end
  end

endmodule

// File: tb/tb_dvp_gray_scale.sv
// Bench for dvp_gray_scale: directed latency, colour, stall and reset cases, then a
// long random valid/ready run scored against an arithmetic luma model.
module tb_dvp_gray_scale;

  localparam int RGB_PXL_W = 16;
  localparam int GS_PXL_W  = 8;
`ifdef GS_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dvp_gray_scale_if #(.RGB_PXL_W(RGB_PXL_W), .GS_PXL_W(GS_PXL_W)) bus ();

  dvp_gray_scale #(.RGB_PXL_W(RGB_PXL_W), .GS_PXL_W(GS_PXL_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rgb_pxl_i     (bus.rgb_pxl),
    .rgb_pxl_vld_i (bus.rgb_pxl_vld),
    .rgb_pxl_rdy_o (bus.rgb_pxl_rdy),
    .gs_pxl_o      (bus.gs_pxl),
    .gs_pxl_vld_o  (bus.gs_pxl_vld),
    .gs_pxl_rdy_i  (bus.gs_pxl_rdy)
  );

  // ---------------- scoreboard state ----------------
  logic [GS_PXL_W-1:0] exp_q[$];
  int                  n_checks = 0;
  int                  n_fail   = 0;
  int                  n_out    = 0;
  logic                prev_stall = 1'b0;
  logic [GS_PXL_W-1:0] prev_gs    = '0;
  logic                saw_rdy_low = 1'b0;

  logic [15:0]         prim_pix[3] = '{16'hF800, 16'h07E0, 16'h001F};
`ifdef GS_ROUND_EN
  logic [7:0]          prim_exp[3] = '{8'd77, 8'd149, 8'd29};
`else
  logic [7:0]          prim_exp[3] = '{8'd76, 8'd149, 8'd28};
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Luma from the channel definitions: replicate MSBs to 8 bits, weight, divide by 256.
  function automatic logic [GS_PXL_W-1:0] ref_gray(input logic [15:0] p);
    int v, r5, g6, b5, r8, g8, b8;
    v  = int'(p);
    r5 = v / 2048;
    g6 = (v / 32) % 64;
    b5 = v % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return GS_PXL_W'((77 * r8 + 150 * g8 + 29 * b8 + RND) / 256);
  endfunction

  // Sampled mid-cycle: what is seen here is what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("rdy_vs_occupancy", 32'(bus.rgb_pxl_rdy),
            32'(exp_q.size() < 2 || bus.gs_pxl_rdy));
      check("occupancy_le2", 32'(exp_q.size() <= 2), 32'd1);
      if (prev_stall) begin
        check("stall_vld_hold", 32'(bus.gs_pxl_vld), 32'd1);
        check("stall_data_hold", 32'(bus.gs_pxl), 32'(prev_gs));
      end
      if (!bus.rgb_pxl_rdy) saw_rdy_low = 1'b1;
      if (bus.gs_pxl_vld && bus.gs_pxl_rdy) begin
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("out_data", 32'(bus.gs_pxl), 32'(exp_q.pop_front()));
        n_out++;
      end
      if (bus.rgb_pxl_vld && bus.rgb_pxl_rdy) exp_q.push_back(ref_gray(bus.rgb_pxl));
      prev_stall = bus.gs_pxl_vld && !bus.gs_pxl_rdy;
      prev_gs    = bus.gs_pxl;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.rgb_pxl_vld = 1'b0;
    bus.gs_pxl_rdy  = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_latency();
    bus.gs_pxl_rdy  = 1'b1;
    bus.rgb_pxl_vld = 1'b1;
    bus.rgb_pxl     = 16'hFFFF;
    tick();
    check("lat_e1_vld", 32'(bus.gs_pxl_vld), 32'd0);
    bus.rgb_pxl = 16'h0000;
    tick();
    check("lat_e2_vld", 32'(bus.gs_pxl_vld), 32'd1);
    check("white", 32'(bus.gs_pxl), 32'd255);
    bus.rgb_pxl_vld = 1'b0;
    tick();
    check("lat_e3_vld", 32'(bus.gs_pxl_vld), 32'd1);
    check("black", 32'(bus.gs_pxl), 32'd0);
    tick();
    check("lat_e4_idle", 32'(bus.gs_pxl_vld), 32'd0);
  endtask

  task automatic test_primaries();
    bus.gs_pxl_rdy  = 1'b1;
    bus.rgb_pxl_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) bus.rgb_pxl = prim_pix[k];
      else       bus.rgb_pxl_vld = 1'b0;
      tick();
      if (k >= 1 && k <= 3) begin
        check("prim_vld", 32'(bus.gs_pxl_vld), 32'd1);
        check("prim_val", 32'(bus.gs_pxl), 32'(prim_exp[k-1]));
      end
    end
    check("prim_idle", 32'(bus.gs_pxl_vld), 32'd0);
  endtask

  task automatic test_backpressure();
    logic [15:0] pix8[8];
    int          i, out0;
    logic        hs;
    for (int k = 0; k < 8; k++) pix8[k] = 16'($urandom);
    i           = 0;
    out0        = n_out;
    saw_rdy_low = 1'b0;
    for (int c = 0; c < 40 && i < 8; c++) begin
      bus.rgb_pxl_vld = 1'b1;
      bus.rgb_pxl     = pix8[i];
      bus.gs_pxl_rdy  = !(c >= 3 && c <= 6);
      @(negedge clk);
      hs = bus.rgb_pxl_rdy;
      tick();
      if (hs) i++;
    end
    bus.rgb_pxl_vld = 1'b0;
    bus.gs_pxl_rdy  = 1'b1;
    repeat (4) tick();
    check("bp_all_sent", 32'(i), 32'd8);
    check("bp_rdy_dropped", 32'(saw_rdy_low), 32'd1);
    check("bp_out_count", 32'(n_out - out0), 32'd8);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_stall();
    logic [15:0]         p;
    logic [GS_PXL_W-1:0] e;
    p               = 16'($urandom);
    e               = ref_gray(p);
    bus.gs_pxl_rdy  = 1'b0;
    bus.rgb_pxl_vld = 1'b1;
    bus.rgb_pxl     = p;
    tick();
    bus.rgb_pxl_vld = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("hold_vld", 32'(bus.gs_pxl_vld), 32'd1);
      check("hold_val", 32'(bus.gs_pxl), 32'(e));
      tick();
    end
    bus.gs_pxl_rdy = 1'b1;
    tick();
    check("hold_release", 32'(bus.gs_pxl_vld), 32'd0);
  endtask

  task automatic test_mid_reset();
    int out0;
    bus.gs_pxl_rdy  = 1'b0;
    bus.rgb_pxl_vld = 1'b1;
    bus.rgb_pxl     = 16'hFFFF;
    tick();
    bus.rgb_pxl     = 16'h07E0;
    tick();
    bus.rgb_pxl_vld = 1'b0;
    check("pre_rst_full", 32'(bus.rgb_pxl_rdy), 32'd0);
    out0  = n_out;
    rst_n = 1'b0;
    tick();
    check("rst_mid_vld", 32'(bus.gs_pxl_vld), 32'd0);
    check("rst_mid_data", 32'(bus.gs_pxl), 32'd0);
    check("rst_mid_rdy", 32'(bus.rgb_pxl_rdy), 32'd1);
    rst_n          = 1'b1;
    bus.gs_pxl_rdy = 1'b1;
    repeat (3) tick();
    check("rst_no_out", 32'(n_out - out0), 32'd0);
  endtask

  task automatic test_random();
    int   sent, out0;
    logic hs;
    sent = 0;
    out0 = n_out;
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      bus.rgb_pxl_vld = ($urandom_range(0, 3) != 0);
      bus.rgb_pxl     = 16'($urandom);
      bus.gs_pxl_rdy  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = bus.rgb_pxl_vld && bus.rgb_pxl_rdy;
      tick();
      if (hs) sent++;
    end
    bus.rgb_pxl_vld = 1'b0;
    bus.gs_pxl_rdy  = 1'b1;
    repeat (6) tick();
    check("rand_sent", 32'(sent), 32'd10000);
    check("rand_out_count", 32'(n_out - out0), 32'(sent));
    check("rand_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.rgb_pxl     = '0;
    bus.rgb_pxl_vld = 1'b0;
    bus.gs_pxl_rdy  = 1'b1;
    rst_n           = 1'b0;
    repeat (3) tick();
    check("reset_vld", 32'(bus.gs_pxl_vld), 32'd0);
    check("reset_rdy", 32'(bus.rgb_pxl_rdy), 32'd1);
    check("reset_data", 32'(bus.gs_pxl), 32'd0);
    rst_n = 1'b1;
    tick();

    test_latency();
    go_idle();
    test_primaries();
    go_idle();
    test_backpressure();
    go_idle();
    test_stall();
    go_idle();
    test_mid_reset();
    go_idle();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_gray_scale.md
DVP_GRAY_SCALE -- requirements
Module: dvp_gray_scale

Interface
REQ-001 SHALL have parameter RGB_PXL_W, 16, input RGB565 pixel width.
REQ-002 SHALL have parameter GS_PXL_W, 8, output gray-scale pixel width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rgb_pxl_i  input  RGB_PXL_W  RGB565 pixel from the DVP state machine: R=[15:11], G=[10:5], B=[4:0].
REQ-006 SHALL have port rgb_pxl_vld_i  input  1  input pixel valid.
REQ-007 SHALL have port rgb_pxl_rdy_o  output  1  input pixel ready.
REQ-008 SHALL have port gs_pxl_o  output  GS_PXL_W  gray-scale pixel.
REQ-009 SHALL have port gs_pxl_vld_o  output  1  output pixel valid.
REQ-010 SHALL have port gs_pxl_rdy_i  input  1  downstream ready.

Function
REQ-011 SHALL transfer an input pixel only when rgb_pxl_vld_i & rgb_pxl_rdy_o are both high in the same cycle; the output handshake SHALL use gs_pxl_vld_o & gs_pxl_rdy_i in the same way.
REQ-012 SHALL expand each channel to 8 bits by bit replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-013 Stage 1 SHALL register the products 77*R8, 150*G8 and 29*B8, each 16 bits wide.
REQ-014 Stage 2 SHALL register Y=(sum of products [+128 with rounding enabled])>>8, truncated to GS_PXL_W; the 16-bit sum SHALL never overflow (max 65408).
REQ-015 SHALL have a latency of exactly 2 cycles from input handshake to gs_pxl_vld_o high when gs_pxl_rdy_i is held high.
REQ-016 SHALL sustain a throughput of 1 pixel/cycle with continuous valid and ready.
REQ-017 Each stage SHALL accept new data when it is empty or its contents move on in the same cycle: s2_en=~s2_vld|gs_pxl_rdy_i; s1_en=~s1_vld|s2_en; rgb_pxl_rdy_o=s1_en.
REQ-018 Under a stall (gs_pxl_rdy_i low), gs_pxl_o and gs_pxl_vld_o SHALL hold stable, and at most 2 pixels SHALL be buffered with none dropped or duplicated.
REQ-019 The pipeline SHALL preserve pixel order.
REQ-020 A simultaneous output drain and input accept SHALL advance both stages in one cycle.

Reset
REQ-021 When rst_n is low at a rising edge, the block SHALL clear both stage valids, the product registers and gs_pxl_o to 0.
REQ-022 During reset, gs_pxl_vld_o SHALL be 0 and rgb_pxl_rdy_o SHALL be 1 (combinational from the cleared valids).
REQ-023 Reset asserted mid-operation SHALL discard in-flight pixels with no output handshake on the following cycle.

Configuration
REQ-024 When macro GS_ROUND_EN is defined, the block SHALL add a constant 128 before the >>8 (round-to-nearest).
REQ-025 When GS_ROUND_EN is undefined, the block SHALL omit the adder term (truncation); interface and latency SHALL be identical in both builds.

Structure
REQ-026 Package dvp_pkg SHALL hold GS_COEF_R=77, GS_COEF_G=150, GS_COEF_B=29, GS_SHIFT=8 and GS_ROUND_CONST=128.
REQ-027 Channel expansion SHALL be one combinational sub-module, rgb565_expand (16-bit in, three 8-bit outputs); the pipeline SHALL stay in the top level.

Verification
REQ-028 Send 0xFFFF, then 0x0000, with ready high: outputs SHALL be 255 then 0, 2 cycles after each input, in both builds.
REQ-029 Send 0xF800, 0x07E0, 0x001F: outputs SHALL be 76, 149, 28 without GS_ROUND_EN, and 77, 149, 29 with it.
REQ-030 Stream 8 back-to-back pixels with ready held low for cycles 3-6: rgb_pxl_rdy_o SHALL drop once 2 pixels are held, and all 8 outputs SHALL emerge in order with no loss.
REQ-031 Hold gs_pxl_rdy_i low with one pixel pending: gs_pxl_o and gs_pxl_vld_o SHALL stay constant until ready rises, then complete in 1 cycle.
REQ-032 Assert rst_n low for 1 cycle with 2 pixels in flight: the next cycle SHALL show gs_pxl_vld_o=0, gs_pxl_o=0, rgb_pxl_rdy_o=1.
REQ-033 Apply random valid/ready toggling over 10k pixels: the output stream SHALL equal the reference-model stream exactly.
